// File: rtl/ram_march_tester_if.sv
// RAM-side bus of the march tester: address, write data, strobes, read data.
// The tester owns the address/data/strobes; the RAM returns data_outbit.
interface ram_march_tester_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_BUS_WIDTH = 4
);
   logic [ADDR_BUS_WIDTH-1:0] address_loc;
   logic [DATA_WIDTH-1:0]     data_inbit;
   logic                      write_en;
   logic                      read_en;
   logic [DATA_WIDTH-1:0]     data_outbit;

   modport master (
      output address_loc,
      output data_inbit,
      output write_en,
      output read_en,
      input  data_outbit
   );

   modport slave (
      input  address_loc,
      input  data_inbit,
      input  write_en,
      input  read_en,
      output data_outbit
   );
endinterface

// File: rtl/ram_march_tester.sv
// March C- style RAM tester.
// Runs M0 up w(P); M1 up r(P) w(~P); M2 up r(~P) w(P); M3 down r(P) w(~P);
// M4 down r(~P) w(P); M5 down r(P) over the DEPTH = 2**ADDR_BUS_WIDTH words
// and stops on the first mismatching read.
//
// RAM bus protocol: one operation per strobe cycle. write_en=1 stores
// data_inbit at address_loc in that cycle. read_en=1 in cycle N requests the
// word at address_loc; data_outbit holds it during cycle N+READ_LATENCY and is
// compared at the end of that cycle. The tester never raises both strobes and
// issues nothing between a read and its compare.
//
// Every output comes straight from a register: the combinational process
// computes next-cycle values, the sequential process stores them.
module ram_march_tester #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_BUS_WIDTH = 4,
   parameter int READ_LATENCY   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     pattern,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic [ADDR_BUS_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0]     fail_data,
   output logic [DATA_WIDTH-1:0]     fail_expected,
   output logic [2:0]                fail_element,
   output logic [2:0]                state_dbg,
   ram_march_tester_if.master        ram
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      WAIT  = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [ADDR_BUS_WIDTH-1:0] LAST_ADDR = {ADDR_BUS_WIDTH{1'b1}};
   localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_ONE  = ADDR_BUS_WIDTH'(1);
   // Extra WAIT cycles between READ and CHECK are READ_LATENCY-1; the counter
   // is loaded with that number minus one and CHECK follows when it hits zero.
   localparam logic [1:0] WAIT_LOAD = 2'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
   localparam logic [2:0] LAST_ELEM = 3'd5;

   // Current-cycle registers
   state_t                    state_q;
   logic [2:0]                elem_q;
   logic [DATA_WIDTH-1:0]     pat_q;
   logic [1:0]                wait_q;
   logic [ADDR_BUS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     din_q;
   logic                      we_q;
   logic                      re_q;

   // Next-cycle values
   state_t                    state_d;
   logic [2:0]                elem_d;
   logic [DATA_WIDTH-1:0]     pat_d;
   logic [1:0]                wait_d;
   logic [ADDR_BUS_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0]     din_d;
   logic                      we_d;
   logic                      re_d;
   logic                      busy_d;
   logic                      done_d;
   logic                      pass_d;
   logic                      fail_d;
   logic [ADDR_BUS_WIDTH-1:0] fail_addr_d;
   logic [DATA_WIDTH-1:0]     fail_data_d;
   logic [DATA_WIDTH-1:0]     fail_expected_d;
   logic [2:0]                fail_element_d;

   // Element-derived helpers
   logic [DATA_WIDTH-1:0]     exp_rd;
   logic [DATA_WIDTH-1:0]     wr_val;
   logic                      going_down;
   logic                      at_last;
   logic [ADDR_BUS_WIDTH-1:0] addr_step;
   logic [2:0]                elem_inc;
   logic [ADDR_BUS_WIDTH-1:0] first_addr;

   assign ram.address_loc = addr_q;
   assign ram.data_inbit  = din_q;
   assign ram.write_en    = we_q;
   assign ram.read_en     = re_q;
   assign state_dbg       = state_q;

   // Odd elements read P and write ~P; even elements read ~P and write P.
   // Elements 3..5 walk downward; the address only wraps between elements.
   always_comb begin
      exp_rd     = elem_q[0] ? pat_q : ~pat_q;
      wr_val     = elem_q[0] ? ~pat_q : pat_q;
      going_down = (elem_q >= 3'd3);
      at_last    = going_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
      addr_step  = going_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
      elem_inc   = elem_q + 3'd1;
      first_addr = (elem_inc >= 3'd3) ? LAST_ADDR : '0;
   end

   // Next-state and next-output logic; strobes default low every cycle.
   always_comb begin
      state_d         = state_q;
      elem_d          = elem_q;
      pat_d           = pat_q;
      wait_d          = wait_q;
      addr_d          = addr_q;
      din_d           = din_q;
      we_d            = 1'b0;
      re_d            = 1'b0;
      busy_d          = busy;
      done_d          = done;
      pass_d          = pass;
      fail_d          = fail;
      fail_addr_d     = fail_addr;
      fail_data_d     = fail_data;
      fail_expected_d = fail_expected;
      fail_element_d  = fail_element;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d         = WRITE;
               elem_d          = 3'd0;
               pat_d           = pattern;
               addr_d          = '0;
               din_d           = pattern;
               we_d            = 1'b1;
               busy_d          = 1'b1;
               done_d          = 1'b0;
               pass_d          = 1'b0;
               fail_d          = 1'b0;
               fail_addr_d     = '0;
               fail_data_d     = '0;
               fail_expected_d = '0;
               fail_element_d  = 3'd0;
            end
         end

         WRITE: begin
            if (at_last) begin
               // Element finished: next element always begins with a read.
               elem_d  = elem_inc;
               addr_d  = first_addr;
               state_d = READ;
               re_d    = 1'b1;
            end else begin
               addr_d = addr_step;
               if (elem_q == 3'd0) begin
                  state_d = WRITE;
                  we_d    = 1'b1;
                  din_d   = wr_val;
               end else begin
                  state_d = READ;
                  re_d    = 1'b1;
               end
            end
         end

         READ: begin
            wait_d = WAIT_LOAD;
            if (READ_LATENCY == 1) begin
               state_d = CHECK;
            end else begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (wait_q == 2'd0) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end

         CHECK: begin
            if (ram.data_outbit != exp_rd) begin
               state_d         = DONE;
               busy_d          = 1'b0;
               done_d          = 1'b1;
               pass_d          = 1'b0;
               fail_d          = 1'b1;
               fail_addr_d     = addr_q;
               fail_data_d     = ram.data_outbit;
               fail_expected_d = exp_rd;
               fail_element_d  = elem_q;
            end else if (elem_q != LAST_ELEM) begin
               // Read-then-write element: write the complement at the same address.
               state_d = WRITE;
               we_d    = 1'b1;
               din_d   = wr_val;
            end else if (at_last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end else begin
               addr_d  = addr_step;
               state_d = READ;
               re_d    = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         elem_q        <= 3'd0;
         pat_q         <= '0;
         wait_q        <= 2'd0;
         addr_q        <= '0;
         din_q         <= '0;
         we_q          <= 1'b0;
         re_q          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         fail_addr     <= '0;
         fail_data     <= '0;
         fail_expected <= '0;
         fail_element  <= 3'd0;
      end else begin
         state_q       <= state_d;
         elem_q        <= elem_d;
         pat_q         <= pat_d;
         wait_q        <= wait_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
         we_q          <= we_d;
         re_q          <= re_d;
         busy          <= busy_d;
         done          <= done_d;
         pass          <= pass_d;
         fail          <= fail_d;
         fail_addr     <= fail_addr_d;
         fail_data     <= fail_data_d;
         fail_expected <= fail_expected_d;
         fail_element  <= fail_element_d;
      end
   end

endmodule
